// File: rtl/matmul_pkg.sv
// matmul_pkg: shared state type and width/latency helpers for the matmul core and its stream bridge.
package matmul_pkg;

    typedef enum logic [1:0] {LOAD_A, LOAD_B, COMPUTE, DRAIN} bridge_state_t;

    function automatic int w_c(int wa, int wb, int c1);
        return wa + wb + $clog2(c1);
    endfunction

    function automatic int latency(int c1);
        return $clog2(c1) + 1;
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/matmul_stream_bridge.sv
// matmul_stream_bridge: loads A/B from a stream, runs the matmul core for its latency, streams C out.
// Define MATMUL_BRIDGE_LAST_CHECK_EN to enable the sticky s_last framing check on err.
module matmul_stream_bridge
    import matmul_pkg::*;
#(
    parameter int R1 = 2,
    parameter int C1 = 2,
    parameter int R2 = 2,
    parameter int C2 = 1,
    parameter int W_A = 8,
    parameter int W_B = 8,
    localparam int W_IN = imax(W_A, W_B),
    localparam int W_C = w_c(W_A, W_B, C1)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [W_IN-1:0]         s_data,
    input  logic                    s_last,
    output logic [R1*C1*W_A-1:0]    A,
    output logic [R2*C2*W_B-1:0]    B,
    output logic                    cen,
    input  logic [R1*C2*W_C-1:0]    C,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [W_C-1:0]          m_data,
    output logic                    m_last,
    output logic                    err
);

    localparam int LAT = latency(C1);
    localparam int NA = R1 * C1;
    localparam int NB = R2 * C2;
    localparam int NC = R1 * C2;
    localparam int CW = $clog2(imax(imax(NA, NB), NC) + 1);
    localparam int LW = $clog2(LAT + 1);

    if (R2 != C1) begin : g_dim_check
        $error("matmul_stream_bridge: R2 must equal C1");
    end

    bridge_state_t state, nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [LW-1:0] lcnt;
    logic [R1*C2*W_C-1:0] cbuf;
    logic lat_done;

    assign lat_done = lcnt == LW'(LAT - 1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= LOAD_A;
            cnt <= '0;
            lcnt <= '0;
            A <= '0;
            B <= '0;
            cbuf <= '0;
        end else begin
            state <= nxt;
            cnt <= cnt_nxt;
            for (int i = 0; i < NA; i++)
                if (s_valid && state == LOAD_A && cnt == CW'(i)) A[i*W_A +: W_A] <= s_data[W_A-1:0];
            for (int i = 0; i < NB; i++)
                if (s_valid && state == LOAD_B && cnt == CW'(i)) B[i*W_B +: W_B] <= s_data[W_B-1:0];
            if (cen) lcnt <= lat_done ? '0 : lcnt + 1'b1;
            if (cen && lat_done) cbuf <= C;
        end
    end

    always_comb begin
        nxt = state;
        cnt_nxt = cnt;
        s_ready = state == LOAD_A || state == LOAD_B;
        cen = state == COMPUTE;
        m_valid = state == DRAIN;
        m_last = m_valid && cnt == CW'(NC - 1);
        m_data = '0;
        for (int i = 0; i < NC; i++)
            if (cnt == CW'(i)) m_data = cbuf[i*W_C +: W_C];
        case (state)
            LOAD_A: if (s_valid) begin
                cnt_nxt = (cnt == CW'(NA - 1)) ? '0 : cnt + 1'b1;
                nxt = (cnt == CW'(NA - 1)) ? LOAD_B : LOAD_A;
            end
            LOAD_B: if (s_valid) begin
                cnt_nxt = (cnt == CW'(NB - 1)) ? '0 : cnt + 1'b1;
                nxt = (cnt == CW'(NB - 1)) ? COMPUTE : LOAD_B;
            end
            COMPUTE: nxt = lat_done ? DRAIN : COMPUTE;
            DRAIN: if (m_ready) begin
                cnt_nxt = m_last ? '0 : cnt + 1'b1;
                nxt = m_last ? LOAD_A : DRAIN;
            end
            default: nxt = LOAD_A;
        endcase
    end

`ifdef MATMUL_BRIDGE_LAST_CHECK_EN
    logic bad_frame;

    // s_last must be high on the final B element and nowhere else
    assign bad_frame = s_valid && s_ready &&
        ((state == LOAD_A) ? s_last : (s_last != (cnt == CW'(NB - 1))));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) err <= 1'b0;
        else if (bad_frame) err <= 1'b1;
    end
`else
    logic unused_last;

    assign unused_last = s_last;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_stream_bridge.sv
// tb_matmul_stream_bridge: scoreboard bench for the stream bridge with a behavioural matmul core.
module tb_matmul_stream_bridge;

    localparam int W_C = 17;
    localparam int LAT = 2;

    logic clk = 0;
    logic rstn;
    logic s_valid, s_ready, s_last;
    logic [7:0] s_data;
    logic [31:0] A;
    logic [15:0] B;
    logic cen;
    logic [2*W_C-1:0] C;
    logic m_valid, m_ready, m_last, err;
    logic [W_C-1:0] m_data;

    typedef struct {int d; bit l;} exp_t;
    exp_t q[$];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    matmul_stream_bridge dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .A(A), .B(B), .cen(cen), .C(C), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .err(err)
    );

    // core stand-in: one register stage, so C is ready on the edge ending the second cen cycle
    function automatic logic [2*W_C-1:0] mm(logic [31:0] a, logic [15:0] b);
        logic [2*W_C-1:0] res;
        res = '0;
        for (int r = 0; r < 2; r++) begin
            int s;
            s = 0;
            for (int k = 0; k < 2; k++) s += $signed(a[(r*2+k)*8 +: 8]) * $signed(b[k*8 +: 8]);
            res[r*W_C +: W_C] = s[W_C-1:0];
        end
        return res;
    endfunction

    always @(posedge clk or negedge rstn)
        if (!rstn) C <= '0;
        else if (cen) C <= mm(A, B);

    task automatic chk(string n, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    bit stall;
    logic [W_C-1:0] held_d;
    logic held_l;
    int cen_run = 0;

    always @(negedge clk) begin
        if (!rstn) begin
            stall = 0;
            cen_run = 0;
        end else begin
            if (stall && m_valid) begin
                chk("stall_data_stable", int'(m_data), int'(held_d));
                chk("stall_last_stable", int'(m_last), int'(held_l));
            end
            if (m_valid && m_ready) begin
                if (q.size() == 0) chk("unexpected_output", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("m_data", int'($signed(m_data)), e.d);
                    chk("m_last", int'(m_last), int'(e.l));
                end
            end
            stall = m_valid && !m_ready;
            held_d = m_data;
            held_l = m_last;
            if (cen) cen_run++;
            else if (cen_run != 0) begin
                chk("cen_cycles", cen_run, LAT);
                cen_run = 0;
            end
        end
    end

    task automatic send(int v, bit l);
        int t;
        s_valid = 1;
        s_data = 8'(v);
        s_last = l;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!s_ready && t < 300);
        if (!s_ready) chk("s_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic job(int a0, int a1, int a2, int a3, int b0, int b1, int e0, int e1,
                       int gap, int lastidx, bit push);
        int v[6];
        v = '{a0, a1, a2, a3, b0, b1};
        if (push) begin
            q.push_back('{e0, 1'b0});
            q.push_back('{e1, 1'b1});
        end
        for (int i = 0; i < 6; i++) begin
            send(v[i], i == lastidx);
            if (gap > 0 && ((i * gap) % 3) != 0) begin
                s_valid = 0;
                repeat ((i * gap) % 3) @(posedge clk);
                #1;
            end
        end
        s_valid = 0;
        s_last = 0;
    endtask

    task automatic wait_empty();
        int t;
        t = 0;
        while ((q.size() != 0 || m_valid) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        while (!m_valid && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("m_valid_timeout", int'(m_valid), 1);
    endtask

    task automatic do_reset();
        rstn = 0;
        q.delete();
        @(negedge clk);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_cen", int'(cen), 0);
        chk("rst_s_ready", int'(s_ready), 1);
        chk("rst_err", int'(err), 0);
        @(posedge clk);
        #1 rstn = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rstn = 0;
        s_valid = 0;
        s_data = 0;
        s_last = 0;
        m_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_s_ready", int'(s_ready), 1);
        chk("reset_cen", int'(cen), 0);
        chk("reset_m_valid", int'(m_valid), 0);
        chk("reset_m_last", int'(m_last), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_A", int'(A), 0);
        chk("reset_B", int'(B), 0);
        @(posedge clk);
        #1 rstn = 1;

        job(1, 2, 3, 4, 5, 6, 17, 39, 0, 5, 1);
        wait_empty();
        chk("err_clean_frame", int'(err), 0);
        chk("A_held", int'(A), 32'h04030201);
        chk("B_held", int'(B), 16'h0605);

        job(-1, -128, 127, 0, -128, -1, 256, -16256, 0, 5, 1);
        wait_empty();

        m_ready = 0;
        job(1, 2, 3, 4, 5, 6, 17, 39, 2, 5, 1);
        wait_valid();
        repeat (3) begin
            @(negedge clk);
            chk("stall_s_ready", int'(s_ready), 0);
        end
        @(posedge clk);
        #1 m_ready = 1;
        wait_empty();

        job(10, -3, 7, 2, 4, -5, 55, 18, 0, 5, 1);
        job(127, 127, 127, 127, 127, 127, 32258, 32258, 0, 5, 1);
        job(-128, -128, -128, -128, -128, -128, 32768, 32768, 0, 5, 1);
        job(1, 2, 3, 4, 5, 6, 17, 39, 0, 5, 1);
        wait_empty();

        for (int i = 0; i < 5; i++) send(9 + i, 0);
        s_valid = 0;
        #2;
        do_reset();
        job(1, 2, 3, 4, 5, 6, 17, 39, 0, 5, 1);
        wait_empty();

        m_ready = 0;
        job(1, 2, 3, 4, 5, 6, 17, 39, 0, 5, 1);
        wait_valid();
        #2;
        do_reset();
        m_ready = 1;
        job(1, 2, 3, 4, 5, 6, 17, 39, 0, 5, 1);
        wait_empty();

        job(1, 2, 3, 4, 5, 6, 17, 39, 0, 3, 1);
        wait_empty();
`ifdef MATMUL_BRIDGE_LAST_CHECK_EN
        chk("err_bad_frame", int'(err), 1);
`else
        chk("err_bad_frame", int'(err), 0);
`endif
        do_reset();
        job(1, 2, 3, 4, 5, 6, 17, 39, 0, 5, 1);
        wait_empty();
        chk("err_good_frame", int'(err), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
